// File: rtl/vx_warp_ctl_pkg.sv
// Shared warp-control definitions: thread/warp counts, warp-ID width, PC step.
package vx_warp_ctl_pkg;

    localparam int unsigned NT      = 4;            // threads per warp
    localparam int unsigned NW      = 8;            // warp count, power of two 2..32
    localparam int unsigned NW_BITS = $clog2(NW);   // warp-ID width
    localparam logic [31:0] PC_STEP = 32'd4;        // sequential fetch step

    typedef logic [NW_BITS-1:0] warp_id_t;
    typedef logic [NT-1:0]      tmask_t;

    // Mask with only lane 0 enabled: how a freshly started warp begins.
    function automatic tmask_t lane0_mask();
        return tmask_t'(1);
    endfunction

endpackage

// File: rtl/vx_warp_ctl_if.sv
// Warp-control bus: pipeline feedback in, issue information out.
interface vx_warp_ctl_if;
    import vx_warp_ctl_pkg::*;

    logic          stall;
    logic [NW-1:0] in_warp_stall;
    logic          in_change_mask;
    warp_id_t      in_cm_warp_num;
    tmask_t        in_thread_mask;
    logic          in_jal;
    logic [31:0]   in_jal_dest;
    logic          in_branch_dir;
    logic [31:0]   in_branch_dest;
    warp_id_t      in_ctl_warp_num;
    logic          in_wspawn;
    logic [31:0]   in_wspawn_pc;
    logic [31:0]   out_PC;
    tmask_t        out_valid;
    warp_id_t      out_warp_num;
    logic          out_fire;
    logic          out_busy;

    // Pipeline side: drives feedback, observes the issued warp.
    modport master (
        output stall, in_warp_stall, in_change_mask, in_cm_warp_num, in_thread_mask,
               in_jal, in_jal_dest, in_branch_dir, in_branch_dest, in_ctl_warp_num,
               in_wspawn, in_wspawn_pc,
        input  out_PC, out_valid, out_warp_num, out_fire, out_busy
    );

    // Warp controller side.
    modport slave (
        input  stall, in_warp_stall, in_change_mask, in_cm_warp_num, in_thread_mask,
               in_jal, in_jal_dest, in_branch_dir, in_branch_dest, in_ctl_warp_num,
               in_wspawn, in_wspawn_pc,
        output out_PC, out_valid, out_warp_num, out_fire, out_busy
    );

endinterface

// File: rtl/vx_warp_ctl_rr_arbiter.sv
// Round-robin picker: first requester after ptr, wrapping modulo NW.
module vx_warp_ctl_rr_arbiter
    import vx_warp_ctl_pkg::*;
(
    input  logic [NW-1:0] request,
    input  warp_id_t      ptr,
    output logic [NW-1:0] grant,
    output warp_id_t      grant_idx,
    output logic          grant_valid
);

    warp_id_t idx;

    // Scan ptr+1 .. ptr+NW; NW is a power of two so the index wraps naturally.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        idx         = '0;
        for (int i = 1; i <= int'(NW); i++) begin
            idx = ptr + warp_id_t'(i);
            if (!grant_valid && request[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        grant = grant_valid ? (NW'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/vx_warp_ctl.sv
// Warp controller: per-warp PC/mask state and zero-latency round-robin issue.
module vx_warp_ctl
    import vx_warp_ctl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    vx_warp_ctl_if.slave  bus
);

    logic [31:0]   pc_q   [NW];
    logic [31:0]   pc_d   [NW];
    tmask_t        mask_q [NW];
    tmask_t        mask_d [NW];
    warp_id_t      rr_ptr_q, rr_ptr_d;

    logic [NW-1:0] active;
    logic [NW-1:0] eligible;
    logic [NW-1:0] grant;
    warp_id_t      grant_idx;
    logic          grant_valid;

    // A warp is active whenever it has any live thread; global stall blocks all issue.
    always_comb begin
        for (int w = 0; w < int'(NW); w++) begin
            active[w]   = |mask_q[w];
            eligible[w] = active[w] && !bus.in_warp_stall[w] && !bus.stall;
        end
    end

    vx_warp_ctl_rr_arbiter u_rr_arbiter (
        .request     (eligible),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Issue outputs come straight from registered state, never from same-cycle updates.
    always_comb begin
        bus.out_fire     = grant_valid;
        bus.out_PC       = grant_valid ? pc_q[grant_idx]   : 32'h0;
        bus.out_valid    = grant_valid ? mask_q[grant_idx] : '0;
        bus.out_warp_num = grant_valid ? grant_idx         : rr_ptr_q;
        bus.out_busy     = |active;
    end

    // Next state, lowest priority first: pc is +4 < redirect < wspawn,
    // mask is wspawn < change_mask. Spawn eligibility uses the current active set.
    always_comb begin
        rr_ptr_d = grant_valid ? grant_idx : rr_ptr_q;
        for (int w = 0; w < int'(NW); w++) begin
            pc_d[w]   = pc_q[w];
            mask_d[w] = mask_q[w];
            if (grant[w]) begin
                pc_d[w] = pc_q[w] + PC_STEP;
            end
            if (bus.in_ctl_warp_num == warp_id_t'(w)) begin
                if (bus.in_jal) begin
                    pc_d[w] = bus.in_jal_dest;
                end else if (bus.in_branch_dir) begin
                    pc_d[w] = bus.in_branch_dest;
                end
            end
            if (bus.in_wspawn && (w != 0) && !active[w]) begin
                pc_d[w]   = bus.in_wspawn_pc;
                mask_d[w] = lane0_mask();
            end
            if (bus.in_change_mask && (bus.in_cm_warp_num == warp_id_t'(w))) begin
                mask_d[w] = bus.in_thread_mask;
            end
        end
    end

    // State registers; reset leaves only warp 0 running and points rr at the last warp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= warp_id_t'(NW - 1);
            for (int w = 0; w < int'(NW); w++) begin
                pc_q[w]   <= (w == 0) ? RESET_PC : 32'h0;
                mask_q[w] <= (w == 0) ? lane0_mask() : '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int w = 0; w < int'(NW); w++) begin
                pc_q[w]   <= pc_d[w];
                mask_q[w] <= mask_d[w];
            end
        end
    end

endmodule

// File: tb/tb_vx_warp_ctl.sv
// Randomized and directed bench for vx_warp_ctl against a behavioural warp model.
module tb_vx_warp_ctl;
    import vx_warp_ctl_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    vx_warp_ctl_if wif ();

    vx_warp_ctl #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wif.slave)
    );

    always #5 clk = ~clk;

    // Reference state: one pc and thread mask per warp, plus last issued warp.
    logic [31:0] m_pc   [NW];
    logic [NT-1:0] m_mask [NW];
    int          m_ptr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < int'(NW); w++) begin
            m_pc[w]   = (w == 0) ? RESET_PC : 32'h0;
            m_mask[w] = (w == 0) ? 1 : 0;
        end
        m_ptr = NW - 1;
    endtask

    // Next ready warp after the last issued one, or -1.
    function automatic int pick();
        for (int k = 1; k <= int'(NW); k++) begin
            int w;
            w = (m_ptr + k) % NW;
            if (m_mask[w] != 0 && !wif.in_warp_stall[w] && !wif.stall) return w;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        wif.stall          = 1'b0;
        wif.in_warp_stall  = '0;
        wif.in_change_mask = 1'b0;
        wif.in_cm_warp_num = '0;
        wif.in_thread_mask = '0;
        wif.in_jal         = 1'b0;
        wif.in_jal_dest    = '0;
        wif.in_branch_dir  = 1'b0;
        wif.in_branch_dest = '0;
        wif.in_ctl_warp_num = '0;
        wif.in_wspawn      = 1'b0;
        wif.in_wspawn_pc   = '0;
    endtask

    // Called at negedge with inputs driven: check outputs, then advance the model.
    task automatic step();
        int   s;
        logic exp_busy;
        #1;
        s = pick();
        exp_busy = 1'b0;
        for (int w = 0; w < int'(NW); w++) if (m_mask[w] != 0) exp_busy = 1'b1;
        check_val("fire", 32'(wif.out_fire), 32'(s >= 0));
        if (s >= 0) begin
            check_val("warp_num", 32'(wif.out_warp_num), 32'(s));
            check_val("pc", wif.out_PC, m_pc[s]);
            check_val("valid", 32'(wif.out_valid), 32'(m_mask[s]));
        end else begin
            check_val("idle_warp_num", 32'(wif.out_warp_num), 32'(m_ptr));
            check_val("idle_pc", wif.out_PC, 32'h0);
            check_val("idle_valid", 32'(wif.out_valid), 32'h0);
        end
        check_val("busy", 32'(wif.out_busy), 32'(exp_busy));
        @(posedge clk);
        if (s >= 0) begin
            m_pc[s] = m_pc[s] + 32'd4;
            m_ptr   = s;
        end
        if (wif.in_jal) m_pc[wif.in_ctl_warp_num] = wif.in_jal_dest;
        else if (wif.in_branch_dir) m_pc[wif.in_ctl_warp_num] = wif.in_branch_dest;
        if (wif.in_wspawn) begin
            for (int w = 1; w < int'(NW); w++) begin
                if (m_mask[w] == 0) begin
                    m_pc[w]   = wif.in_wspawn_pc;
                    m_mask[w] = 1;
                end
            end
        end
        if (wif.in_change_mask) m_mask[wif.in_cm_warp_num] = wif.in_thread_mask;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_fire"}, 32'(wif.out_fire), 32'h1);
        check_val({tag, "_warp"}, 32'(wif.out_warp_num), 32'h0);
        check_val({tag, "_pc"}, wif.out_PC, RESET_PC);
        check_val({tag, "_valid"}, 32'(wif.out_valid), 32'h1);
        check_val({tag, "_busy"}, 32'(wif.out_busy), 32'h1);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Idle warp 0 alone: PCs 0, 4, 8.
        repeat (3) step();

        // Spawn the remaining warps at 0x100 and let them rotate.
        wif.in_wspawn    = 1'b1;
        wif.in_wspawn_pc = 32'h100;
        step();
        clear_inputs();
        repeat (10) step();

        // jal and branch together on warp 0 while it issues.
        for (int k = 0; k < 2 * int'(NW) && pick() != 0; k++) step();
        check_val("w0_due", 32'(pick()), 32'h0);
        wif.in_jal          = 1'b1;
        wif.in_jal_dest     = 32'h200;
        wif.in_branch_dir   = 1'b1;
        wif.in_branch_dest  = 32'h300;
        wif.in_ctl_warp_num = '0;
        step();
        clear_inputs();
        repeat (9) step();

        // Kill warp 2.
        wif.in_change_mask = 1'b1;
        wif.in_cm_warp_num = warp_id_t'(2);
        wif.in_thread_mask = '0;
        step();
        clear_inputs();
        repeat (10) step();

        // Global stall for three cycles.
        wif.stall = 1'b1;
        repeat (3) step();
        clear_inputs();
        repeat (5) step();

        // Warp 0 PC wraps through 0xFFFFFFFC.
        wif.in_jal          = 1'b1;
        wif.in_jal_dest     = 32'hFFFF_FFFC;
        wif.in_ctl_warp_num = '0;
        step();
        clear_inputs();
        repeat (2 * NW) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            wif.stall           = ($urandom % 8) == 0;
            wif.in_warp_stall   = NW'($urandom & $urandom);
            wif.in_change_mask  = ($urandom % 10) == 0;
            wif.in_cm_warp_num  = warp_id_t'($urandom);
            wif.in_thread_mask  = tmask_t'($urandom);
            wif.in_jal          = ($urandom % 8) == 0;
            wif.in_jal_dest     = $urandom;
            wif.in_branch_dir   = ($urandom % 6) == 0;
            wif.in_branch_dest  = $urandom;
            wif.in_ctl_warp_num = warp_id_t'($urandom);
            wif.in_wspawn       = ($urandom % 12) == 0;
            wif.in_wspawn_pc    = $urandom;
            step();
        end
        clear_inputs();

        // Asynchronous reset in the middle of a cycle.
        step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vx_warp_ctl.md
VX_WARP_CTL -- requirements
Module: VX_warp_ctl

Interface
REQ-001 Parameter NT, default 4: threads per warp.
REQ-002 Parameter NW, default 8: warp count; power of two, 2 to 32.
REQ-003 Parameter RESET_PC, default 32'h0: warp 0 start PC.
REQ-004 clk  in  1: the single clock.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 stall  in  1: global fetch stall.
REQ-007 in_warp_stall  in  NW: per-warp hold, for example from the scoreboard.
REQ-008 in_change_mask, in_cm_warp_num  in  1, log2(NW): thread-mask update strobe and target warp.
REQ-009 in_thread_mask  in  NT: new thread mask.
REQ-010 in_jal, in_jal_dest  in  1, 32: jump redirect.
REQ-011 in_branch_dir, in_branch_dest  in  1, 32: taken-branch redirect.
REQ-012 in_ctl_warp_num  in  log2(NW): target warp of a jump or branch redirect.
REQ-013 in_wspawn, in_wspawn_pc  in  1, 32: warp-spawn strobe and start PC.
REQ-014 out_PC  out  32: PC of the issued warp.
REQ-015 out_valid  out  NT: thread mask of the issued warp.
REQ-016 out_warp_num  out  log2(NW): issued warp ID.
REQ-017 out_fire  out  1: an issue is happening this cycle.
REQ-018 out_busy  out  1: at least one warp is active.

Function
REQ-019 Per-warp state SHALL be pc[32], mask[NT] and active; a warp SHALL be active exactly when its mask is nonzero.
REQ-020 A warp SHALL be eligible when it is active, its in_warp_stall bit is low, and stall is low.
REQ-021 Selection SHALL be combinational round-robin, searching from rr_ptr+1 mod NW and taking the first eligible warp.
REQ-022 With no eligible warp: out_fire=0, out_valid=0, out_PC=0, out_warp_num=rr_ptr.
REQ-023 On issue: out_fire=1, out_PC=pc[sel], out_valid=mask[sel], out_warp_num=sel; these outputs SHALL NOT bypass same-cycle updates.
REQ-024 At the clock edge after an issue: pc[sel] <= pc[sel]+4 (mod 2^32), and rr_ptr <= sel.
REQ-025 rr_ptr SHALL hold when there is no issue.
REQ-026 Redirect: if in_jal, pc[in_ctl_warp_num] <= in_jal_dest; otherwise, if in_branch_dir, pc[in_ctl_warp_num] <= in_branch_dest.
REQ-027 A jal SHALL win over a branch in the same cycle.
REQ-028 A redirect SHALL win over the +4 increment when it targets the issued warp.
REQ-029 in_change_mask SHALL set mask[in_cm_warp_num] <= in_thread_mask; an all-zero mask deactivates the warp and leaves its pc unchanged.
REQ-030 in_wspawn SHALL give each inactive warp 1..NW-1 pc <= in_wspawn_pc and mask <= lane 0 only; active warps and warp 0 SHALL be unaffected.
REQ-031 On the same warp in the same cycle, priority for mask SHALL be change_mask over wspawn.
REQ-032 On the same warp in the same cycle, priority for pc SHALL be wspawn over redirect over +4 increment.
REQ-033 stall SHALL freeze only issue; mask, redirect and wspawn updates SHALL still apply.
REQ-034 out_busy SHALL equal the OR of all active bits; when all warps go inactive, out_busy SHALL drop on the following cycle.
REQ-035 Issue latency SHALL be 0 cycles from eligibility to out_fire.

Reset
REQ-036 Reset SHALL set warp 0 to pc=RESET_PC and mask=1 (lane 0); all other warps to pc=0, mask=0; and rr_ptr=NW-1.
REQ-037 The first issue after reset SHALL therefore be warp 0.
REQ-038 Reset asserted mid-operation SHALL restore these values immediately, asynchronously, and outputs SHALL follow within the same cycle.

Structure
REQ-039 NT, NW, the log2(NW) width and the +4 PC step SHALL be defined in the shared VX_define header; no local redefinition.
REQ-040 The round-robin picker SHALL be a separate sub-module, VX_rr_arbiter (request NW, pointer in, grant one-hot plus index out, valid out).
REQ-041 Per-warp state SHALL be flat register arrays in VX_warp_ctl; target size is 150 to 300 lines.

Verification
REQ-042 Reset, then idle -> out_fire=1, out_warp_num=0, out_PC=0, then 4, 8 on consecutive cycles; out_valid=0001.
REQ-043 wspawn PC=0x100 at cycle 3 -> warps 1-7 active, issue order 0,1,2,...,7,0; each new warp's first out_PC=0x100.
REQ-044 in_jal dest=0x200 and in_branch_dir dest=0x300 together on warp 0 while warp 0 issues -> next warp-0 issue out_PC=0x200.
REQ-045 change_mask warp 2 to 0000 while warps 0-3 are active -> warp 2 is never issued again; warp order 0,1,3 repeats.
REQ-046 Global stall for 3 cycles -> out_fire=0 throughout, PCs unchanged, and round-robin resumes at the next warp after the last one issued.
REQ-047 Warp 0 PC at 0xFFFFFFFC issues -> next out_PC=0; then reset asserted mid-stream -> outputs return to the reset state immediately.
